requant_round_sat: RTL and testbench

- Downstream consumer of the quantization right shifter.
- Takes the shifter's signed result, which carries TAIL_BIT fractional bits, and rounds it to an integer (round-half-up).
- Saturates the integer to the signed OUT_WIDTH activation range and emits it over a valid/ready stream toward the output buffer.
- Two-stage elastic pipeline; also provides a saturation-event counter for debug and calibration.

---
 rtl/requant_round_sat.sv | 205 ++++++++++++++++++++
 tb/tb_requant_round_sat.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_round_sat.sv
// ---------------------------------------------------------------------------
// requant_round_sat
//
// Purpose:
//   Sits behind the quantization right shifter. Takes its signed fixed-point
//   result (TAIL_BIT fractional bits), rounds it half toward +infinity,
//   saturates the integer into the signed OUT_WIDTH activation range and
//   streams it to the output buffer over valid/ready. The block is a
//   two-stage elastic pipeline: stage 1 rounds, stage 2 saturates. A sticky
//   saturation-event counter is provided for debug and calibration.
//
// Build option:
//   RQ_RELU_EN - when defined, stage 2 clamps negative rounded values to 0
//                before the range check. ReLU clipping does not count as a
//                saturation event; only overflow above MAX does.
//
// Parameters:
//   IN_WIDTH  - width of the signed input (matches the shifter output)
//   TAIL_BIT  - fractional bits carried by i_data, 1..IN_WIDTH-2
//   OUT_WIDTH - width of the signed output
//   CNT_WIDTH - width of the saturation counter
//
// Ports:
//   i_clk      clock, rising edge
//   i_rstn     asynchronous active-low reset, discards in-flight data
//   i_valid    upstream data valid
//   o_ready    block can accept i_data this cycle (combinational from i_ready)
//   i_data     signed fixed-point input
//   i_last     tile-last flag, travels with its data
//   i_clr_cnt  synchronous clear of o_sat_cnt, wins over an increment
//   o_valid    output data valid
//   i_ready    downstream ready
//   o_data     rounded, saturated result
//   o_last     i_last of the element currently on o_data
//   o_sat_cnt  number of saturated outputs delivered, sticks at all-ones
// ---------------------------------------------------------------------------
module requant_round_sat #(
    parameter int IN_WIDTH  = 15,
    parameter int TAIL_BIT  = 5,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [IN_WIDTH-1:0]  i_data,
    input  logic                        i_last,
    input  logic                        i_clr_cnt,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic                        o_last,
    output logic [CNT_WIDTH-1:0]        o_sat_cnt
);

    // Rounded integer width: one guard bit on top of the input, minus the
    // fractional bits that rounding removes.
    localparam int R1W = IN_WIDTH + 1 - TAIL_BIT;

    // Compare width: wide enough to hold both r1 and the output range with
    // a sign bit to spare, so the range check never wraps whatever the
    // parameter mix is.
    localparam int CW = ((R1W > OUT_WIDTH) ? R1W : OUT_WIDTH) + 1;

    // Half an LSB of the integer result, added before truncation.
    localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (TAIL_BIT - 1);

    // Output range limits, sign-extended to the compare width.
    localparam logic signed [CW-1:0] SAT_MAX =
        $signed({{(CW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}});
    localparam logic signed [CW-1:0] SAT_MIN =
        $signed({{(CW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}});

    localparam logic [CNT_WIDTH-1:0] CNT_TOP = '1;

    generate
        if (TAIL_BIT < 1 || TAIL_BIT > IN_WIDTH - 2) begin : g_bad_tail
            $error("requant_round_sat: TAIL_BIT must be in 1..IN_WIDTH-2");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Pipeline control
    // -----------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic adv1;
    logic adv2;

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv2    = !s2_valid || i_ready;
    assign adv1    = !s1_valid || adv2;
    assign o_ready = adv1;

    // -----------------------------------------------------------------------
    // Stage 1: round half toward +infinity
    // -----------------------------------------------------------------------
    logic [IN_WIDTH:0]   sum;
    logic [R1W-1:0]      r1;
    logic                unused_frac;
    logic signed [R1W-1:0] s1_r1;
    logic                s1_last;

    // Sign-extend by one bit so adding HALF to the largest input cannot
    // overflow. Taking the bits above the fraction is the arithmetic shift
    // right by TAIL_BIT, truncated to R1W.
    assign sum = {i_data[IN_WIDTH-1], i_data} + HALF;
    assign r1  = sum[IN_WIDTH:TAIL_BIT];

    // Fraction bits are intentionally discarded after rounding.
    assign unused_frac = ^sum[TAIL_BIT-1:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_r1    <= '0;
            s1_last  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= i_valid;
            end
            if (adv1 && i_valid) begin
                s1_r1   <= $signed(r1);
                s1_last <= i_last;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: optional ReLU, then saturate to the OUT_WIDTH range
    // -----------------------------------------------------------------------
    logic signed [CW-1:0]        r1_x;
    logic signed [CW-1:0]        r1_c;
    logic signed [OUT_WIDTH-1:0] sat_data;
    logic                        sat_flag;

    logic signed [OUT_WIDTH-1:0] s2_data;
    logic                        s2_last;
    logic                        s2_sat;

    assign r1_x = {{(CW - R1W){s1_r1[R1W-1]}}, s1_r1};

`ifdef RQ_RELU_EN
    // Negative activations clip to zero; this is not a saturation event.
    assign r1_c = r1_x[CW-1] ? '0 : r1_x;
`else
    assign r1_c = r1_x;
`endif

    always_comb begin
        sat_data = r1_c[OUT_WIDTH-1:0];
        sat_flag = 1'b0;
        if (r1_c > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_WIDTH-1:0];
            sat_flag = 1'b1;
        end else if (r1_c < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_WIDTH-1:0];
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
            end
            // Holding the payload when not advancing keeps o_data/o_last
            // stable through a downstream stall.
            if (adv2 && s1_valid) begin
                s2_data <= sat_data;
                s2_last <= s1_last;
                s2_sat  <= sat_flag;
            end
        end
    end

    assign o_valid = s2_valid;
    assign o_data  = s2_data;
    assign o_last  = s2_last;

    // -----------------------------------------------------------------------
    // Saturation-event counter: counts delivered saturated outputs, sticks at
    // all-ones so a long calibration run never reads back a small value.
    // -----------------------------------------------------------------------
    logic out_xfer;

    assign out_xfer = s2_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_sat_cnt <= '0;
        end else if (i_clr_cnt) begin
            o_sat_cnt <= '0;
        end else if (out_xfer && s2_sat && (o_sat_cnt != CNT_TOP)) begin
            o_sat_cnt <= o_sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_requant_round_sat.sv
// ---------------------------------------------------------------------------
// tb_requant_round_sat
//   Scoreboard bench for requant_round_sat. Stimulus pushes the expected
//   result into a queue when an input transfer is seen; a monitor on the
//   falling edge pops and compares on every output transfer and tracks the
//   expected saturation counter. Expected values come from directed tables
//   or from an arithmetic reference model (floor division, clamp).
// ---------------------------------------------------------------------------
module tb_requant_round_sat;

    localparam int IW = 15;
    localparam int TB = 5;
    localparam int OW = 8;
    localparam int CWID = 16;
    localparam int OMAX = (1 << (OW - 1)) - 1;
    localparam int OMIN = -(1 << (OW - 1));
    localparam int CMAX = (1 << CWID) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [IW-1:0]   i_data = '0;
    logic            i_last = 1'b0;
    logic            i_clr_cnt = 1'b0;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic [OW-1:0]   o_data;
    logic            o_last;
    logic [CWID-1:0] o_sat_cnt;

    requant_round_sat #(
        .IN_WIDTH (IW),
        .TAIL_BIT (TB),
        .OUT_WIDTH(OW),
        .CNT_WIDTH(CWID)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_last   (i_last),
        .i_clr_cnt(i_clr_cnt),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_sat_cnt(o_sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
        bit sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   exp_cnt = 0;
    bit   chk_lat = 1'b0;
    bit   saw_block = 1'b0;
    bit   prev_stall = 1'b0;
    int   prev_data = 0;
    bit   prev_last = 1'b0;
    bit   rnd_done = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: value/2^TB rounded half up is floor((x + 2^(TB-1)) / 2^TB).
    function automatic int ref_round(input int x);
        int n, d, qt;
        n = x + (1 << (TB - 1));
        d = 1 << TB;
        qt = n / d;
        if (n < 0 && (n % d) != 0) qt = qt - 1;
        return qt;
    endfunction

    function automatic void ref_sat(input int x, output int y, output bit s);
        int r;
        r = ref_round(x);
`ifdef RQ_RELU_EN
        if (r < 0) r = 0;
`endif
        s = 1'b0;
        y = r;
        if (r > OMAX) begin
            y = OMAX;
            s = 1'b1;
        end else if (r < OMIN) begin
            y = OMIN;
            s = 1'b1;
        end
    endfunction

    // Monitor: compares counter every cycle and payload on each transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            exp_t e;
            chk("sat_cnt", int'(o_sat_cnt), exp_cnt);
            if (prev_stall) begin
                chk("stall_data_stable", int'($signed(o_data)), prev_data);
                chk("stall_last_stable", int'(o_last), int'(prev_last));
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("o_data", int'($signed(o_data)), e.data);
                    chk("o_last", int'(o_last), int'(e.last));
                    if (chk_lat) chk("latency", cyc - e.cyc, 2);
                    if (e.sat && exp_cnt != CMAX) exp_cnt++;
                end
            end
            if (i_clr_cnt) exp_cnt = 0;
            prev_stall = o_valid && !i_ready;
            prev_data  = int'($signed(o_data));
            prev_last  = o_last;
            if (!o_ready) saw_block = 1'b1;
        end
    end

    // Drive one element and wait for its transfer. use_tab selects a directed
    // expected value instead of the model's.
    task automatic send(input int x, input bit last, input bit use_tab, input int tab);
        exp_t e;
        int y;
        bit s;
        ref_sat(x, y, s);
        e.data = use_tab ? tab : y;
        e.last = last;
        e.sat  = s;
        i_valid = 1'b1;
        i_data  = IW'(x);
        i_last  = last;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (o_ready) begin
                e.cyc = cyc;
                q.push_back(e);
                @(posedge clk);
                #1;
                i_valid = 1'b0;
                i_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 1, 0);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        i_clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        i_clr_cnt = 1'b0;
    endtask

    int rnd_in[5]  = '{48, -48, 16, -16, 31};
`ifdef RQ_RELU_EN
    int rnd_out[5] = '{2, 0, 1, 0, 1};
    int sat_out[4] = '{127, 127, 0, 0};
    int sat_n      = 2;
`else
    int rnd_out[5] = '{2, -1, 1, 0, 1};
    int sat_out[4] = '{127, 127, -128, -128};
    // -4112 rounds to exactly -128, which is in range: three events, not four.
    int sat_n      = 3;
`endif
    int sat_in[4]  = '{4080, 16383, -16384, -4112};

    initial begin
        // Reset values
        #3;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_data", int'(o_data), 0);
        chk("rst_o_last", int'(o_last), 0);
        chk("rst_o_sat_cnt", int'(o_sat_cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_o_ready", int'(o_ready), 1);
        @(posedge clk);
        #1;

        // Rounding, unstalled latency
        i_ready = 1'b1;
        chk_lat = 1'b1;
        for (int i = 0; i < 5; i++) send(rnd_in[i], 1'b0, 1'b1, rnd_out[i]);
        drain();
        chk_lat = 1'b0;

        // Saturation
        clear_cnt();
        for (int i = 0; i < 4; i++) send(sat_in[i], 1'b0, 1'b1, sat_out[i]);
        drain();
        chk("sat_case_cnt", int'(o_sat_cnt), sat_n);

        // Backpressure: i_ready low in cycles 3..6 of the burst
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(i * 613 - 3000, (i == 9), 1'b0, 0);
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    i_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                i_ready = 1'b1;
            end
        join
        drain();
        chk("bp_o_ready_dropped", int'(saw_block), 1);

        // Randomized traffic with random backpressure and occasional clears
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    int x;
                    x = int'($urandom_range(0, 32767)) - 16384;
                    if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 8191)) - 4096;
                    send(x, ($urandom_range(0, 7) == 0), 1'b0, 0);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    i_ready   = ($urandom_range(0, 9) < 7);
                    i_clr_cnt = ($urandom_range(0, 49) == 0);
                    @(posedge clk);
                    #1;
                end
                i_ready   = 1'b1;
                i_clr_cnt = 1'b0;
            end
        join
        drain();

        // Counter stick at all-ones
        clear_cnt();
        for (int i = 0; i < CMAX - 1; i++) send(16383, 1'b0, 1'b0, 0);
        drain();
        chk("cnt_fffe", int'(o_sat_cnt), CMAX - 1);
        for (int i = 0; i < 3; i++) send(16383, 1'b0, 1'b0, 0);
        drain();
        chk("cnt_stick", int'(o_sat_cnt), CMAX);

        // Clear coinciding with a saturated output transfer
        send(16383, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("clr_pre_o_valid", int'(o_valid), 1);
        i_clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        i_clr_cnt = 1'b0;
        chk("clr_priority", int'(o_sat_cnt), 0);

        // Mid-stream reset with both stages full
        i_ready = 1'b0;
        send(100, 1'b0, 1'b0, 0);
        send(-100, 1'b1, 1'b0, 0);
        chk("mid_o_ready_full", int'(o_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_o_valid_drop", int'(o_valid), 0);
        q.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_stale", int'(o_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
